// File: rtl/inst_burst_rsp_if.sv
// Read-address / read-data channel bundle between a burst requester and inst_burst_rsp.
// master drives the request and the beat-consume strobe; slave returns the beats.
interface inst_burst_rsp_if;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arlen, arsize, arvalid, rready,
        input  arready, rdata, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arvalid, rready,
        output arready, rdata, rlast, rvalid
    );
endinterface

// File: rtl/inst_burst_rsp.sv
// Burst read responder: backdoor-loaded word memory serving one read burst at a time.
// First beat LAT+1 cycles after the address handshake; a beat holds while rready is low.
module inst_burst_rsp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_burst_rsp_if.slave       bus,
    input  logic                  mem_we,
    input  logic [DEPTH_LOG2-1:0] mem_waddr,
    input  logic [31:0]           mem_wdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t                state, state_nxt;
    logic [DEPTH_LOG2-1:0] ptr;
    logic [3:0]            cnt;
    logic [3:0]            len;
    logic [2:0]            dly;
    logic [31:0]           mem [DEPTH];

    logic arready_c, rvalid_c, rlast_c;
    logic ar_hs, r_hs, is_last, dly_done;

    assign ar_hs    = bus.arvalid && arready_c;
    assign r_hs     = rvalid_c && bus.rready;
    assign is_last  = (cnt == len);
    assign dly_done = (({1'b0, dly} + 4'd1) == 4'(LAT));

    // Byte offset and address bits beyond the memory are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{bus.arsize, bus.araddr[31:DEPTH_LOG2+2], bus.araddr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        rlast_c   = 1'b0;
        case (state)
            IDLE: begin
                arready_c = !rst;
                if (ar_hs) state_nxt = (LAT > 0) ? WAIT : BURST;
            end
            WAIT: begin
                if (dly_done) state_nxt = BURST;
            end
            BURST: begin
                rvalid_c = 1'b1;
                rlast_c  = is_last;
                if (bus.rready && is_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
            len <= '0;
            dly <= '0;
        end else begin
            if (ar_hs) begin
                ptr <= bus.araddr[DEPTH_LOG2+1:2];
                cnt <= '0;
                len <= bus.arlen;
                dly <= '0;
            end
            if (state == WAIT) dly <= dly + 3'd1;
            // Pointer wraps naturally at DEPTH because it is exactly DEPTH_LOG2 bits wide.
            if (r_hs && !is_last) begin
                ptr <= ptr + DEPTH_LOG2'(1);
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Contents survive reset so a reset mid-burst does not lose the preload.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.arready = arready_c;
    assign bus.rvalid  = rvalid_c;
    assign bus.rlast   = rlast_c;
    assign bus.rdata   = mem[ptr];
endmodule

// File: doc/inst_burst_rsp.md
INST_BURST_RSP -- requirements
Module: inst_burst_rsp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter LAT, default 2, idle cycles between address acceptance and first rvalid (range 0..7).
REQ-003 SHALL have clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have araddr  input  32  burst start byte address.
REQ-006 SHALL have arlen  input  4  burst length minus one (1..16 beats).
REQ-007 SHALL have arsize  input  3  beat size; accepted, ignored; every beat is one 32-bit word.
REQ-008 SHALL have arvalid  input  1  read request valid.
REQ-009 SHALL have arready  output  1  request accepted when arvalid&arready.
REQ-010 SHALL have rdata  output  32  read beat data.
REQ-011 SHALL have rlast  output  1  final beat of burst.
REQ-012 SHALL have rvalid  output  1  beat valid.
REQ-013 SHALL have rready  input  1  beat consumed when rvalid&rready.
REQ-014 SHALL have mem_we  input  1  backdoor word write enable.
REQ-015 SHALL have mem_waddr  input  DEPTH_LOG2  backdoor word index.
REQ-016 SHALL have mem_wdata  input  32  backdoor write data.

Function
REQ-017 SHALL hold a DEPTH-word array (DEPTH=2^DEPTH_LOG2); contents not reset.
REQ-018 SHALL implement FSM IDLE, WAIT, BURST; one outstanding burst, no request overlap.
REQ-019 IDLE: arready=1, rvalid=0; on arvalid&arready latch word pointer=araddr[DEPTH_LOG2+1:2], beat counter=0, length=arlen; go WAIT if LAT>0, else BURST.
REQ-020 araddr[1:0] and araddr bits above DEPTH_LOG2+1 SHALL be ignored.
REQ-021 WAIT: arready=0, rvalid=0; delay counter runs LAT cycles, then BURST; first rvalid exactly LAT+1 cycles after handshake edge.
REQ-022 BURST: arready=0, rvalid=1, rdata=mem[pointer] (combinational read), rlast=(counter==length).
REQ-023 While rvalid&!rready, pointer, counter, rdata source, rlast SHALL hold.
REQ-024 On rvalid&rready, not last: pointer+1 modulo DEPTH (wraps DEPTH-1 to 0), counter+1; next beat presented next cycle (no bubble).
REQ-025 On rvalid&rready&rlast: go IDLE; rvalid=0 and arready=1 the following cycle.
REQ-026 Backdoor write SHALL take effect at clock edge in any state; write to word currently presented SHALL change rdata from next cycle.
REQ-027 arvalid SHALL be ignored outside IDLE; a request held across a busy period is accepted in first IDLE cycle.
REQ-028 rready SHALL be ignored while rvalid=0.

Reset
REQ-029 In the cycle after rst high: state IDLE, rvalid=0, rlast=0, arready=1, counters 0.
REQ-030 arready SHALL be 0 while rst asserted.
REQ-031 rst mid-burst SHALL abort the burst with no further beats; memory contents retained.

Verification
REQ-032 Preload mem[i]=0x1000_0000+i; araddr=0x40, arlen=7, rready=1 -> handshake at edge k, beats at cycles k+3..k+10 data 0x10000010..0x10000017, rlast only on 8th beat.
REQ-033 Same burst, rready toggles 1,0,0,1,... -> data/rlast stable during stalls, 8 beats in order, no duplicate or skip.
REQ-034 DEPTH_LOG2=10, araddr=0xFF8, arlen=3 -> beats mem[1022],mem[1023],mem[0],mem[1].
REQ-035 LAT=0, arlen=0, araddr=0x7 -> single beat mem[1] with rlast=1 in cycle after handshake; arready=1 the cycle after it is consumed.
REQ-036 arvalid held high during burst with new araddr=0x100 -> ignored until IDLE, then accepted; second burst starts at mem[64].
REQ-037 rst asserted on 3rd beat of 8-beat burst -> rvalid=0 next cycle, arready=1 after rst drop, new burst returns correct data.
